// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - PC sequencer and Branch unit controller
module branch_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic        stall,
  input  logic        dec_valid,
  input  logic        dec_b,
  input  logic        dec_j,
  input  logic [9:0]  dec_pc,
  input  logic        br_taken,
  input  logic [9:0]  br_target,
  output logic [9:0]  pc,
  output logic        fetch_valid,
  output logic        br_en,
  output logic [9:0]  br_addr,
  output logic        flush,
  output logic [15:0] br_count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_EVAL    = 2'd2,
    S_RESOLVE = 2'd3
  } state_t;

  state_t      cur_state, nxt_state;
  // HALT is IDLE with this bit set; it only changes where fetching resumes
  logic        halted, halted_d;
  logic [9:0]  pc_d, br_addr_d;
  logic        fetch_valid_d, br_en_d, flush_d;
  logic [15:0] br_count_d;

  assign state = cur_state;

  // State and all outputs are registered; next values come from the comb block
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state   <= S_IDLE;
      halted      <= 1'b0;
      pc          <= 10'd0;
      fetch_valid <= 1'b0;
      br_en       <= 1'b0;
      br_addr     <= 10'd0;
      flush       <= 1'b0;
      br_count    <= 16'd0;
    end else begin
      cur_state   <= nxt_state;
      halted      <= halted_d;
      pc          <= pc_d;
      fetch_valid <= fetch_valid_d;
      br_en       <= br_en_d;
      br_addr     <= br_addr_d;
      flush       <= flush_d;
      br_count    <= br_count_d;
    end
  end

  // Next-state and next-output decode; br_en and flush are single-cycle pulses
  always_comb begin
    nxt_state     = cur_state;
    halted_d      = halted;
    pc_d          = pc;
    fetch_valid_d = fetch_valid;
    br_en_d       = 1'b0;
    br_addr_d     = br_addr;
    flush_d       = 1'b0;
    br_count_d    = br_count;
    case (cur_state)
      S_IDLE: begin
        fetch_valid_d = 1'b0;
        if (start) begin
          nxt_state     = S_FETCH;
          fetch_valid_d = 1'b1;
          halted_d      = 1'b0;
          if (!halted) pc_d = 10'd0;
        end
      end
      S_FETCH: begin
        fetch_valid_d = 1'b1;
        if (halt_req) begin
          nxt_state     = S_IDLE;
          halted_d      = 1'b1;
          fetch_valid_d = 1'b0;
        end else if (stall) begin
          pc_d = pc;
        end else if (!flush && dec_valid && (dec_b || dec_j)) begin
          // decode contents are being killed while flush is high, so they
          // cannot start a branch; this spaces br_en pulses 4 cycles apart
          nxt_state     = S_EVAL;
          br_addr_d     = dec_pc;
          br_en_d       = 1'b1;
          fetch_valid_d = 1'b0;
        end else begin
          pc_d = pc + 10'd1;
        end
      end
      S_EVAL: begin
        fetch_valid_d = 1'b0;
        nxt_state     = S_RESOLVE;
      end
      S_RESOLVE: begin
        if (br_taken) begin
          pc_d = br_target;
          if (br_count != 16'hFFFF) br_count_d = br_count + 16'd1;
        end else begin
          pc_d = br_addr + 10'd1;
        end
        flush_d       = 1'b1;
        fetch_valid_d = 1'b1;
        nxt_state     = S_FETCH;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - self-checking bench for branch_sequencer
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, halt_req, stall, dec_valid, dec_b, dec_j, br_taken;
  logic [9:0]  dec_pc, br_target;
  logic [9:0]  pc, br_addr;
  logic        fetch_valid, br_en, flush;
  logic [15:0] br_count;
  logic [1:0]  state;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_cnt = 16'd0;

  always #5 clk = ~clk;

  branch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .stall(stall),
    .dec_valid(dec_valid), .dec_b(dec_b), .dec_j(dec_j), .dec_pc(dec_pc),
    .br_taken(br_taken), .br_target(br_target), .pc(pc), .fetch_valid(fetch_valid),
    .br_en(br_en), .br_addr(br_addr), .flush(flush), .br_count(br_count), .state(state)
  );

  wire [40:0] dvec = {pc, fetch_valid, br_en, br_addr, flush, br_count, state};

  // Reference model: "running" fetch flag, halted flag, and a phase counter
  // counting cycles since a branch was accepted (0 = none in flight)
  int m_pc, m_addr, m_cnt, m_phase;
  bit m_fv, m_en, m_flush, m_run, m_halted;

  function automatic logic [40:0] mvec();
    int s;
    s = !m_run ? 0 : (m_phase == 1 ? 2 : (m_phase == 2 ? 3 : 1));
    return {m_pc[9:0], m_fv, m_en, m_addr[9:0], m_flush, m_cnt[15:0], s[1:0]};
  endfunction

  task automatic model_edge();
    bit old_flush;
    if (rst) begin
      m_pc = 0; m_fv = 0; m_en = 0; m_addr = 0; m_flush = 0; m_cnt = 0;
      m_run = 0; m_halted = 0; m_phase = 0;
      return;
    end
    old_flush = m_flush;
    m_flush = 0;
    m_en = 0;
    if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2) begin
      if (br_taken) begin
        m_pc = int'(br_target);
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end else begin
        m_pc = (m_addr + 1) % 1024;
      end
      m_flush = 1; m_fv = 1; m_phase = 0;
    end else if (!m_run) begin
      if (start) begin
        m_run = 1; m_fv = 1;
        if (!m_halted) m_pc = 0;
        m_halted = 0;
      end
    end else if (halt_req) begin
      m_run = 0; m_halted = 1; m_fv = 0;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (dec_valid && (dec_b || dec_j) && !old_flush) begin
      m_addr = int'(dec_pc); m_en = 1; m_fv = 0; m_phase = 1;
    end else begin
      m_pc = (m_pc + 1) % 1024;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; start = 0; halt_req = 0; stall = 0; dec_valid = 0; dec_b = 0; dec_j = 0;
    dec_pc = 0; br_taken = 0; br_target = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    checks++;
    if (dvec !== 41'd0) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", dvec, 41'd0);
    end
    exp_cnt = 16'd0;
  endtask

  task automatic test_sequence();
    bit          st[5]  = '{0, 0, 1, 1, 0};
    logic [9:0]  ep[5]  = '{10'd1, 10'd2, 10'd2, 10'd2, 10'd3};
    start = 1; tick(); start = 0;
    checks++;
    if ({pc, fetch_valid, state} !== {10'd0, 1'b1, 2'd1}) begin
      failures++;
      $display("FAIL start got=%h exp=%h", {pc, fetch_valid, state}, {10'd0, 1'b1, 2'd1});
    end
    for (int i = 0; i < 5; i++) begin
      stall = st[i];
      tick();
      checks++;
      if ({pc, fetch_valid} !== {ep[i], 1'b1}) begin
        failures++;
        $display("FAIL seq_pc step=%0d got=%h exp=%h", i, {pc, fetch_valid}, {ep[i], 1'b1});
      end
    end
    stall = 0;
  endtask

  task automatic test_branch(input bit taken, input logic [9:0] addr, input logic [9:0] target);
    logic [9:0] exp_pc;
    exp_pc = taken ? target : addr + 10'd1;
    if (taken && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    dec_valid = 1; dec_b = 1; dec_pc = addr;
    tick();
    dec_valid = 0; dec_b = 0;
    checks++;
    if ({br_en, fetch_valid, br_addr, state} !== {1'b1, 1'b0, addr, 2'd2}) begin
      failures++;
      $display("FAIL br_detect got=%h exp=%h", {br_en, fetch_valid, br_addr, state}, {1'b1, 1'b0, addr, 2'd2});
    end
    br_taken = taken; br_target = target;
    tick();
    checks++;
    if ({br_en, fetch_valid, flush, br_addr, state} !== {1'b0, 1'b0, 1'b0, addr, 2'd3}) begin
      failures++;
      $display("FAIL br_eval got=%h exp=%h", {br_en, fetch_valid, flush, br_addr, state}, {1'b0, 1'b0, 1'b0, addr, 2'd3});
    end
    tick();
    br_taken = 0;
    checks++;
    if ({pc, flush, fetch_valid, state, br_count} !== {exp_pc, 1'b1, 1'b1, 2'd1, exp_cnt}) begin
      failures++;
      $display("FAIL br_resolve got=%h exp=%h", {pc, flush, fetch_valid, state, br_count}, {exp_pc, 1'b1, 1'b1, 2'd1, exp_cnt});
    end
    tick();
    checks++;
    if ({pc, flush, br_en, br_count} !== {exp_pc + 10'd1, 1'b0, 1'b0, exp_cnt}) begin
      failures++;
      $display("FAIL br_after got=%h exp=%h", {pc, flush, br_en, br_count}, {exp_pc + 10'd1, 1'b0, 1'b0, exp_cnt});
    end
  endtask

  task automatic test_wrap();
    test_branch(1'b1, 10'd7, 10'h3FE);
    tick();
    checks++;
    if (pc !== 10'd0) begin
      failures++;
      $display("FAIL pc_wrap got=%h exp=%h", pc, 10'd0);
    end
    test_branch(1'b0, 10'd1023, 10'h155);
  endtask

  task automatic test_halt();
    test_branch(1'b1, 10'd3, 10'd8);
    halt_req = 1; tick(); halt_req = 0;
    checks++;
    if ({pc, fetch_valid, state} !== {10'd9, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL halt got=%h exp=%h", {pc, fetch_valid, state}, {10'd9, 1'b0, 2'd0});
    end
    tick(); tick();
    checks++;
    if ({pc, fetch_valid, state} !== {10'd9, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL halt_hold got=%h exp=%h", {pc, fetch_valid, state}, {10'd9, 1'b0, 2'd0});
    end
    start = 1; tick(); start = 0;
    checks++;
    if ({pc, fetch_valid, state} !== {10'd9, 1'b1, 2'd1}) begin
      failures++;
      $display("FAIL resume got=%h exp=%h", {pc, fetch_valid, state}, {10'd9, 1'b1, 2'd1});
    end
    dec_valid = 1; dec_b = 1; dec_pc = 10'd20;
    tick();
    dec_valid = 0; dec_b = 0;
    halt_req = 1; start = 1; stall = 1;
    tick();
    checks++;
    if (state !== 2'd3) begin
      failures++;
      $display("FAIL halt_in_eval got=%h exp=%h", state, 2'd3);
    end
    tick();
    halt_req = 0; start = 0; stall = 0;
    checks++;
    if ({pc, flush, fetch_valid, state} !== {10'd21, 1'b1, 1'b1, 2'd1}) begin
      failures++;
      $display("FAIL halt_resolve got=%h exp=%h", {pc, flush, fetch_valid, state}, {10'd21, 1'b1, 1'b1, 2'd1});
    end
    tick();
    checks++;
    if ({pc, fetch_valid, state} !== {10'd22, 1'b1, 2'd1}) begin
      failures++;
      $display("FAIL halt_after got=%h exp=%h", {pc, fetch_valid, state}, {10'd22, 1'b1, 2'd1});
    end
  endtask

  task automatic test_back_to_back();
    int last = -1;
    int pulses = 0;
    dec_valid = 1; dec_j = 1; br_taken = 1;
    for (int i = 0; i < 17; i++) begin
      dec_pc = 10'($urandom);
      br_target = 10'($urandom);
      tick();
      checks++;
      if (dvec !== mvec()) begin
        failures++;
        $display("FAIL b2b_model cyc=%0d got=%h exp=%h", i, dvec, mvec());
      end
      if (br_en === 1'b1) begin
        pulses++;
        if (last >= 0) begin
          checks++;
          if (i - last != 4) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d exp=%0d", i - last, 4);
          end
        end
        last = i;
      end
    end
    checks++;
    if (pulses < 4) begin
      failures++;
      $display("FAIL b2b_pulses got=%0d exp=%0d", pulses, 4);
    end
    idle_inputs();
    tick(); tick();
    exp_cnt = m_cnt[15:0];
  endtask

  task automatic test_saturation();
    force dut.br_count = 16'hFFFE;
    m_cnt = 65534;
    exp_cnt = 16'hFFFE;
    tick();
    release dut.br_count;
    test_branch(1'b1, 10'd40, 10'd100);
    test_branch(1'b1, 10'd41, 10'd200);
    checks++;
    if (br_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL saturate got=%h exp=%h", br_count, 16'hFFFF);
    end
  endtask

  task automatic test_reset_in_eval();
    dec_valid = 1; dec_b = 1; dec_pc = 10'd77;
    tick();
    idle_inputs();
    rst = 1; br_taken = 1; br_target = 10'd300;
    tick();
    rst = 0;
    checks++;
    if (dvec !== 41'd0) begin
      failures++;
      $display("FAIL rst_in_eval got=%h exp=%h", dvec, 41'd0);
    end
    tick();
    checks++;
    if (dvec !== 41'd0) begin
      failures++;
      $display("FAIL rst_stale_ignored got=%h exp=%h", dvec, 41'd0);
    end
    br_taken = 0;
  endtask

  task automatic test_random();
    idle_inputs();
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom % 300) == 0;
      start     = ($urandom % 4) == 0;
      halt_req  = ($urandom % 16) == 0;
      stall     = ($urandom % 5) == 0;
      dec_valid = ($urandom % 2) == 0;
      dec_b     = ($urandom % 3) == 0;
      dec_j     = ($urandom % 3) == 0;
      dec_pc    = 10'($urandom);
      br_taken  = 1'($urandom);
      br_target = 10'($urandom);
      tick();
      checks++;
      if (dvec !== mvec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, dvec, mvec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_sequence();
    test_branch(1'b1, 10'd5, 10'h040);
    test_branch(1'b0, 10'd5, 10'h040);
    test_wrap();
    test_halt();
    test_back_to_back();
    test_saturation();
    test_reset_in_eval();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
